// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and helpers for branch resolution
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    // 2-bit saturating step toward the resolved direction
    function automatic bht_ctr_t ctr_next(bht_ctr_t c, logic taken);
        if (taken) begin
            return (c == ST) ? ST : c + 2'd1;
        end
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch lookup, EX resolve and result bundle
interface branch_resolve_unit_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_stall;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic             res_illegal;
    logic [XLEN-1:0]  res_redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_stall, ex_funct3,
               ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
        input  if_pred_taken, res_valid, res_taken, res_mispredict,
               res_illegal, res_redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_stall, ex_funct3,
               ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
        output if_pred_taken, res_valid, res_taken, res_mispredict,
               res_illegal, res_redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational RV64I branch condition evaluator
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_funct3_e'(funct3))
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolve, redirect, 2-bit BHT and statistics
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int       XLEN        = 64,
    parameter int       BHT_ENTRIES = 64,
    parameter bht_ctr_t INIT_STATE  = WNT,
    parameter int       CNT_W       = 32
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht_q [BHT_ENTRIES];
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic             res_mis_q, res_mis_d;
    logic             res_illegal_q, res_illegal_d;
    logic [XLEN-1:0]  res_redirect_q, res_redirect_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic             cmp_taken;
    logic             cmp_illegal;
    logic             resolve;
    logic             train;
    logic [IDX-1:0]   if_idx;
    logic [IDX-1:0]   ex_idx;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  fallthru;
    logic             unused_if_pc_bits;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (bus.ex_funct3),
        .rs1     (bus.ex_rs1),
        .rs2     (bus.ex_rs2),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign if_idx            = bus.if_pc[IDX+1:2];
    assign ex_idx            = bus.ex_pc[IDX+1:2];
    assign unused_if_pc_bits = ^{bus.if_pc[XLEN-1:IDX+2], bus.if_pc[1:0]};
    assign bus.if_pred_taken = bht_q[if_idx][1];

    assign resolve  = bus.ex_valid & bus.ex_is_branch & ~bus.ex_stall;
    assign train    = resolve & ~cmp_illegal;
    assign target   = bus.ex_pc + bus.ex_imm;
    assign fallthru = bus.ex_pc + XLEN'(4);

    always_comb begin
        res_valid_d    = resolve;
        res_taken_d    = resolve & cmp_taken;
        res_mis_d      = train & (cmp_taken ^ bus.ex_pred_taken);
        res_illegal_d  = resolve & cmp_illegal;
        res_redirect_d = res_redirect_q;
        branch_cnt_d   = branch_cnt_q;
        mis_cnt_d      = mis_cnt_q;
        if (resolve) begin
            res_redirect_d = cmp_taken ? target : fallthru;
        end
        if (train && branch_cnt_q != '1) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (res_mis_d && mis_cnt_q != '1) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Reset wins over a branch sitting in EX, so that branch is simply dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= INIT_STATE;
            end
            res_valid_q    <= 1'b0;
            res_taken_q    <= 1'b0;
            res_mis_q      <= 1'b0;
            res_illegal_q  <= 1'b0;
            res_redirect_q <= '0;
            branch_cnt_q   <= '0;
            mis_cnt_q      <= '0;
        end else begin
            if (train) begin
                bht_q[ex_idx] <= ctr_next(bht_q[ex_idx], cmp_taken);
            end
            res_valid_q    <= res_valid_d;
            res_taken_q    <= res_taken_d;
            res_mis_q      <= res_mis_d;
            res_illegal_q  <= res_illegal_d;
            res_redirect_q <= res_redirect_d;
            branch_cnt_q   <= branch_cnt_d;
            mis_cnt_q      <= mis_cnt_d;
        end
    end

    assign bus.res_valid        = res_valid_q;
    assign bus.res_taken        = res_taken_q;
    assign bus.res_mispredict   = res_mis_q;
    assign bus.res_illegal      = res_illegal_q;
    assign bus.res_redirect_pc  = res_redirect_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;

endmodule
